up_down_counter_32: RTL and testbench
=====================================

Name: up_down_counter_32

Overview:
- Free-running synchronous binary up/down counter, 32 bits wide by default.
- Counts up or down by one on every rising clock edge; a single direction input selects which.
- General-purpose timing/sequence building block.
- No load, no enable, no terminal-count output.

Parameters:
- WIDTH, 32, counter width in bits (must be >= 1). The 32-bit configuration is the production use; other widths exist for verification of wrap behaviour.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- up  input  1  count direction: 1 = increment, 0 = decrement.
- q  output  WIDTH  current count value, driven directly from the state register.

Behaviour:
- Reset
  - reset=1 forces q to 0 immediately, without waiting for a clock edge.
  - q holds 0 for as long as reset is high.
  - up is ignored while reset is high; it may be X/undefined during reset without affecting q.
- Counting
  - On each rising clk edge with reset=0: q <= q+1 if up=1, q <= q-1 if up=0.
  - Exactly one step per clock; no enable, so the counter changes every cycle.
- Latency
  - q reflects the new value immediately after the edge (registered output, zero combinational path from up to q).
  - up is sampled at the rising edge.
- Release from reset
  - On the first rising edge after reset deasserts, q becomes 1 (up=1) or all-ones (up=0).
  - Example: reset released between edges, up=1 -> q=0 until the next edge, then 1, 2, 3, ... on successive edges.
- Arithmetic
  - Unsigned, modulo 2^WIDTH.
  - Up from all-ones (0xFFFFFFFF) wraps to 0; down from 0 wraps to all-ones.
  - No saturation and no overflow flag.
- Direction change
  - Takes effect on the first edge at which the new up value is sampled.
  - No idle cycle; the value continues from where it was.
  - Example: 16 --(up=0)--> 15.
- Reset mid-operation
  - Asserting reset asynchronously clears q to 0 regardless of count or direction.
  - Counting resumes from 0 on the first edge after release.
- No X propagation: q is defined (0) from the first reset assertion onward.

Decomposition:
- Shared package (counter_pkg):
  - Default width constant COUNTER_WIDTH = 32.
  - Typedef count_t = logic [COUNTER_WIDTH-1:0].
- Sub-module updown_step:
  - Purely combinational next-state function (inputs q, up; output q_next).
  - Kept separate from the async-reset state register so it can be reused and unit-checked.
  - Otherwise a single always_ff block.

Test Plan:
- Reset: hold reset=1 for 1.5 clock periods with up=X -> q=0 throughout, including before the first edge.
- Count up: release reset between edges, up=1 -> q=0 immediately after release, then 1,2,...,15 on the following 15 edges (checked mid-cycle each cycle).
- Count down with wrap: from q=16 set up=0 for 20 cycles -> 15,14,...,0, then 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFD, 0xFFFFFFFC.
- Up-wrap: instance with WIDTH=4, up=1 for 17 edges after reset -> 1..15, 0, 1.
- Async reset mid-count: assert reset between edges at q=7 -> q=0 before the next edge; release -> next edge q=1 (up=1).
- Direction toggle every cycle: starting q=5, up alternating 1,0,1,0 -> 6,5,6,5.

Source files
------------

// File: rtl/up_down_counter_32_pkg.sv
// Shared constants and types for the up/down counter slice.
package counter_pkg;
  localparam int COUNTER_WIDTH = 32;

  typedef logic [COUNTER_WIDTH-1:0] count_t;
endpackage

// File: rtl/up_down_counter_32_if.sv
// Direction/count bundle; master drives direction, slave returns the count.
interface up_down_counter_32_if
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
);
  logic             up;
  logic [WIDTH-1:0] q;

  modport master (output up, input  q);
  modport slave  (input  up, output q);
endinterface

// File: rtl/up_down_counter_32_step.sv
// Combinational next-count function: +1 when up, -1 otherwise, modulo 2^WIDTH.
module updown_step
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic [WIDTH-1:0] q_next
);
  always_comb begin
    q_next = '0;
    if (up) q_next = q + WIDTH'(1);
    else    q_next = q - WIDTH'(1);
  end
endmodule

// File: rtl/up_down_counter_32.sv
// Free-running up/down counter with asynchronous active-high reset.
module up_down_counter_32
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;

  updown_step #(.WIDTH(WIDTH)) u_step (
    .q      (r_q),
    .up     (up),
    .q_next (w_q_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= '0;
    else       r_q <= w_q_next;
  end

  assign q = r_q;
endmodule

// File: tb/tb_up_down_counter_32.sv
// Self-checking bench: 32-bit and 4-bit counters against an arithmetic model.
module tb_up_down_counter_32;
  import counter_pkg::*;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  up_down_counter_32_if #(.WIDTH(32)) ia ();
  up_down_counter_32_if #(.WIDTH(4))  ib ();

  up_down_counter_32 #(.WIDTH(32)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .up    (ia.up),
    .q     (ia.q)
  );

  up_down_counter_32 #(.WIDTH(4)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .up    (ib.up),
    .q     (ib.q)
  );

  always #5 clk = ~clk;

  // Reference: count value as plain modular integer arithmetic.
  longint unsigned ma = 0;
  longint unsigned mb = 0;
  localparam longint unsigned MOD_A = 64'd1 << 32;
  localparam longint unsigned MOD_B = 64'd16;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a)      ma = 0;
    else if (ia.up) ma = (ma + 1) % MOD_A;
    else            ma = (ma + MOD_A - 1) % MOD_A;
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b)      mb = 0;
    else if (ib.up) mb = (mb + 1) % MOD_B;
    else            mb = (mb + MOD_B - 1) % MOD_B;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_a", {32'd0, ia.q}, ma);
      check("model_b", {60'd0, ib.q}, mb);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    count_t exp_a;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ia.up = 1'bx;
    ib.up = 1'bx;
    #1;
    check("reset_pre_edge_a", {32'd0, ia.q}, 64'd0);
    check("reset_pre_edge_b", {60'd0, ib.q}, 64'd0);
    chk_en = 1'b1;
    step();
    check("reset_hold_a", {32'd0, ia.q}, 64'd0);
    step();
    rst_a = 1'b0;
    rst_b = 1'b0;
    ia.up = 1'b1;
    ib.up = 1'b1;
    #1;
    check("release_zero", {32'd0, ia.q}, 64'd0);
    #1;

    for (int unsigned i = 1; i <= 15; i++) begin
      step();
      check("count_up", {32'd0, ia.q}, 64'(i));
    end
    check("up_b_15", {60'd0, ib.q}, 64'd15);
    step();
    check("up_a_16", {32'd0, ia.q}, 64'd16);
    check("up_wrap_b_0", {60'd0, ib.q}, 64'd0);

    ia.up = 1'b0;
    for (int unsigned i = 1; i <= 20; i++) begin
      step();
      if (i == 1) check("up_wrap_b_1", {60'd0, ib.q}, 64'd1);
      exp_a = 32'd16 - 32'(i);
      check("count_down", {32'd0, ia.q}, {32'd0, exp_a});
    end
    check("down_wrap_end", {32'd0, ia.q}, 64'h0000_0000_FFFF_FFFC);

    rst_a = 1'b1;
    ia.up = 1'b1;
    step();
    rst_a = 1'b0;
    for (int unsigned i = 0; i < 7; i++) step();
    check("pre_async_7", {32'd0, ia.q}, 64'd7);
    rst_a = 1'b1;
    #1;
    check("async_clear", {32'd0, ia.q}, 64'd0);
    #1;
    rst_a = 1'b0;
    step();
    check("post_async_1", {32'd0, ia.q}, 64'd1);

    for (int unsigned i = 0; i < 4; i++) step();
    check("toggle_start_5", {32'd0, ia.q}, 64'd5);
    for (int unsigned i = 0; i < 4; i++) begin
      ia.up = (i % 2 == 0);
      step();
      check("toggle", {32'd0, ia.q}, (i % 2 == 0) ? 64'd6 : 64'd5);
    end

    for (int unsigned c = 0; c < 3000; c++) begin
      rst_a = ($urandom_range(0, 99) < 3);
      rst_b = ($urandom_range(0, 99) < 3);
      ia.up = $urandom_range(0, 1) == 1;
      ib.up = $urandom_range(0, 1) == 1;
      if (!rst_a && $urandom_range(0, 99) < 2) begin
        rst_a = 1'b1;
        #1;
        check("rand_pulse_a", {32'd0, ia.q}, 64'd0);
        rst_a = 1'b0;
      end
      step();
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
